// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared core state type and sizing helpers
// Purpose: state_t used by the core sequencer and its neighbours, the default
//          register-address width, and the counter-width helper.
// Ports:   none (package).
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'b00,
      ON    = 2'b01,
      STALL = 2'b10,
      FLUSH = 2'b11
   } state_t;

   localparam int REG_ADDR_W = 5;

   // Wide enough to hold the larger terminal count; terminal compares prevent wrap.
   function automatic int cnt_w(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - control bundle between the sequencer and the pipeline
// Purpose: groups the sequencer's inputs (power, decode/EX register fields,
//          branch outcome) and its outputs (PC/IF-ID enables, squashes, state).
// Ports (slave = sequencer view):
//   in : power, id_rs1, id_rs2, ex_rd, ex_mem_read, br_taken
//   out: pc_en, if_id_en, if_id_flush, id_ex_flush, state, core_ready
//   out: perf_stall, perf_flush (only when PIPE_CTRL_PERF_EN is defined)
interface pipeline_ctrl_if import pipeline_ctrl_pkg::*; #(
   parameter int ADDR_W = REG_ADDR_W
);
   logic              power;
   logic [ADDR_W-1:0] id_rs1;
   logic [ADDR_W-1:0] id_rs2;
   logic [ADDR_W-1:0] ex_rd;
   logic              ex_mem_read;
   logic              br_taken;
   logic              pc_en;
   logic              if_id_en;
   logic              if_id_flush;
   logic              id_ex_flush;
   state_t            state;
   logic              core_ready;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]       perf_stall;
   logic [31:0]       perf_flush;
`endif

   modport slave (
      input  power, id_rs1, id_rs2, ex_rd, ex_mem_read, br_taken,
      output pc_en, if_id_en, if_id_flush, id_ex_flush, state, core_ready
`ifdef PIPE_CTRL_PERF_EN
      , output perf_stall, perf_flush
`endif
   );

   modport master (
      output power, id_rs1, id_rs2, ex_rd, ex_mem_read, br_taken,
      input  pc_en, if_id_en, if_id_flush, id_ex_flush, state, core_ready
`ifdef PIPE_CTRL_PERF_EN
      , input perf_stall, perf_flush
`endif
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - load-use hazard compare
// Purpose: flags a load in EX whose destination is read by the instruction in decode.
// Ports:
//   id_rs1, id_rs2 in  source registers of the decode instruction
//   ex_rd          in  destination register of the EX instruction
//   ex_mem_read    in  EX instruction is a load
//   hazard         out stall required
module hazard_detect #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              hazard
);

   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign hazard = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - RV32I 5-stage core sequencer (OFF/ON/STALL/FLUSH)
// Purpose: owns the core state machine and decodes PC enable, IF/ID enable and
//          the IF/ID and ID/EX squash controls from power, load-use hazards and
//          taken branches. Outputs are combinational from state and inputs.
// Ports:
//   clk  in  core clock, rising edge
//   rst  in  asynchronous, active-high reset
//   bus  pipeline_ctrl_if.slave (see rtl/pipeline_ctrl_if.sv)
// Configuration: PIPE_CTRL_PERF_EN adds perf_stall / perf_flush event counters.
module pipeline_ctrl #(
   parameter int PWRUP_CYCLES = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_ADDR_W   = 5
) (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.slave bus
);
   import pipeline_ctrl_pkg::*;

   localparam int CNT_W = cnt_w(PWRUP_CYCLES, FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWRUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pwr_cnt, pwr_cnt_d;
   logic [CNT_W-1:0] flush_cnt, flush_cnt_d;
   logic             core_ready_q;
   logic             hazard;
   logic             pc_en, if_id_en, if_id_flush, id_ex_flush;

   hazard_detect #(.ADDR_W(REG_ADDR_W)) u_hazard (
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .ex_rd       (bus.ex_rd),
      .ex_mem_read (bus.ex_mem_read),
      .hazard      (hazard)
   );

   always_comb begin
      state_d     = state_q;
      pwr_cnt_d   = pwr_cnt;
      flush_cnt_d = flush_cnt;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      case (state_q)
         OFF: begin
            if (!bus.power) begin
               pwr_cnt_d = '0;
            end else if (pwr_cnt == PWR_LAST) begin
               state_d   = ON;
               pwr_cnt_d = '0;
            end else begin
               pwr_cnt_d = pwr_cnt + 1'b1;
            end
         end
         ON, STALL: begin
            if (!bus.power) begin
               state_d     = OFF;
               pwr_cnt_d   = '0;
               flush_cnt_d = '0;
            end else if (bus.br_taken) begin
               // A branch beats a hazard: the hazarding instruction is wrong-path.
               pc_en    = 1'b1;
               if_id_en = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = FLUSH;
                  flush_cnt_d = CNT_W'(1);
               end else begin
                  state_d = ON;
               end
            end else if (state_q == ON && hazard) begin
               // Hold PC and IF/ID, bubble ID/EX; STALL never re-checks the hazard.
               if_id_flush = 1'b0;
               state_d     = STALL;
            end else begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b0;
               id_ex_flush = 1'b0;
               state_d     = ON;
            end
         end
         FLUSH: begin
            if (!bus.power) begin
               state_d     = OFF;
               pwr_cnt_d   = '0;
               flush_cnt_d = '0;
            end else begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
               if (flush_cnt == FLUSH_LAST) begin
                  state_d     = ON;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = flush_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_d     = OFF;
            pwr_cnt_d   = '0;
            flush_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= OFF;
         pwr_cnt      <= '0;
         flush_cnt    <= '0;
         core_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pwr_cnt      <= pwr_cnt_d;
         flush_cnt    <= flush_cnt_d;
         core_ready_q <= (state_d != OFF);
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.if_id_en    = if_id_en;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.state       = state_q;
   assign bus.core_ready  = core_ready_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;
   logic        stall_evt;

   assign stall_evt = (state_q == ON) && bus.power && !bus.br_taken && hazard;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall_evt)
            perf_stall_q <= perf_stall_q + 32'd1;
         if (if_id_flush && state_q != OFF)
            perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign bus.perf_stall = perf_stall_q;
   assign bus.perf_flush = perf_flush_q;
`endif

endmodule
